// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the FIFO-fed UART transmitter:
//     - state_t               : 3-bit encoding of the transmitter FSM states
//     - DEFAULT_CLKS_PER_BIT  : default clk cycles per serial bit
//     - MAX_DATA_WIDTH        : widest data word even_parity() accepts
//     - even_parity()         : parity bit that makes the total number of ones
//                               (data plus parity) even
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int MAX_DATA_WIDTH       = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    // Narrower words are zero-extended by the caller, so the extra zero bits
    // leave the XOR reduction unchanged.
    function automatic logic even_parity(input logic [MAX_DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
//   Bit-period counter for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
//   wraps; tick marks the last cycle of every bit period.
//
//   Ports
//     clk    in   system clock
//     rst    in   asynchronous active-low reset (0 = reset)
//     clear  in   synchronous clear; holds the count at 0 while asserted
//     tick   out  1 while count == CLKS_PER_BIT-1
//     count  out  current position inside the bit period
// ----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            clear,
    output logic                            tick,
    output logic [$clog2(CLKS_PER_BIT)-1:0] count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    assign tick = (count == LAST);

    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // flop samples the pre-edge values of its inputs, independent of the
    // order in which the simulator evaluates always blocks.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || tick) begin
            // Wrapping on tick restarts the period on every bit boundary,
            // which is also what happens on each state change in the FSM.
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule : uart_baud_tick

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain stage for an 8-bit synchronous FIFO. Pops one byte whenever the
//   FIFO is non-empty and new frames are enabled, then serialises it as a
//   UART frame: start bit, LSB-first data, optional even parity, stop bit(s).
//   Frames run back-to-back with a two-cycle (POP, LOAD) gap of idle line.
//
//   Ports
//     clk         in   system clock, rising edge
//     rst         in   asynchronous active-low reset (0 = reset)
//     enable      in   1 = may start new frames; a running frame always ends
//     fifo_empty  in   FIFO empty flag
//     fifo_data   in   FIFO read data, valid the cycle after fifo_pop
//     fifo_pop    out  one-cycle read strobe to the FIFO
//     tx          out  serial line, idles high, driven from a flop
//     busy        out  1 from POP through the last stop-bit cycle
//     frame_done  out  one-cycle pulse on the last cycle of the last stop bit
// ----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [IDX_W-1:0] LAST_DATA    = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP    = IDX_W'(STOP_BITS - 1);

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift;
    logic                    parity_bit;
    logic [IDX_W-1:0]        bit_idx;

    logic                    baud_clear;
    logic                    tick;
    logic [CNT_W-1:0]        baud_count;
    logic                    can_start;

    // Holding the counter at 0 outside the serial states makes START begin
    // a fresh bit period; later state changes coincide with the wrap.
    assign baud_clear = (state == IDLE) || (state == POP) || (state == LOAD);
    assign can_start  = enable && !fifo_empty;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear),
        .tick  (tick),
        .count (baud_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_pop   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            // NOTE: the shift register is datapath, not a memory array, so it
            // is reset along with the control flops; a reset frame leaves no
            // stale byte behind.
            shift      <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
        end else begin
            // Strobes default low each cycle so they can only ever be
            // single-cycle pulses.
            fifo_pop   <= 1'b0;
            frame_done <= 1'b0;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (can_start) begin
                        state    <= POP;
                        fifo_pop <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                POP: begin
                    // The FIFO registers its read on this edge; data is
                    // presented during LOAD.
                    state <= LOAD;
                end

                LOAD: begin
                    shift      <= fifo_data;
                    parity_bit <= even_parity(MAX_DATA_WIDTH'(fifo_data));
                    tx         <= 1'b0;
                    state      <= START;
                end

                START: begin
                    if (tick) begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == LAST_DATA) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity_bit;
                                state <= PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            // tx takes the bit that becomes shift[0] after
                            // this shift, keeping line and register aligned.
                            tx      <= shift[1];
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        tx      <= 1'b1;
                        bit_idx <= '0;
                        state   <= STOP;
                    end
                end

                STOP: begin
                    // frame_done is registered, so it is set one cycle early
                    // to land on the final stop cycle.
                    if ((bit_idx == LAST_STOP) && (baud_count == CNT_PRE_LAST)) begin
                        frame_done <= 1'b1;
                    end
                    if (tick) begin
                        if (bit_idx == LAST_STOP) begin
                            bit_idx <= '0;
                            if (can_start) begin
                                state    <= POP;
                                fifo_pop <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : fifo_uart_tx
